// File: rtl/mux_scan_seq.sv
`default_nettype none
// ============================================================================
// Module   : mux_scan_seq
// Purpose  : Clocked NCH:1 channel selector with a registered valid/ready
//            output stage. Manual mode samples the channel named by sel on
//            every free output slot; auto-scan mode walks an internal
//            channel pointer, taking one sample every DWELL cycles.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk      in   1       rising-edge clock
//   rst_n    in   1       asynchronous active-low reset
//   g_n      in   1       active-low enable; 1 = block disabled, output dropped
//   mode     in   1       0 = manual, 1 = auto-scan
//   sel      in   SW      manual channel select (sel >= NCH yields y = 0)
//   d        in   NCH*W   packed channel data, channel k = d[k*W +: W]
//   ch_mask  in   NCH     scan channel enables (only with SCAN_MASK_EN)
//   y        out  W       registered sample data
//   y_ch     out  SW      channel index of y
//   y_valid  out  1       y/y_ch hold an unconsumed sample
//   y_ready  in   1       consumer handshake, transfer on y_valid & y_ready
// Build option:
//   SCAN_MASK_EN - adds ch_mask; scan skips channels whose mask bit is 0.
// ============================================================================
module mux_scan_seq #(
    parameter  int NCH   = 4,
    parameter  int W     = 1,
    parameter  int DWELL = 4,
    localparam int SW    = $clog2(NCH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              g_n,
    input  logic              mode,
    input  logic [SW-1:0]     sel,
    input  logic [NCH*W-1:0]  d,
`ifdef SCAN_MASK_EN
    input  logic [NCH-1:0]    ch_mask,
`endif
    output logic [W-1:0]      y,
    output logic [SW-1:0]     y_ch,
    output logic              y_valid,
    input  logic              y_ready
);

    localparam int          DW         = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [DW-1:0] c_dwell_max = DW'(DWELL - 1);
    localparam logic [SW-1:0] c_last_ch   = SW'(NCH - 1);

    typedef enum logic [1:0] {
        ST_DIS  = 2'd0,
        ST_MAN  = 2'd1,
        ST_SCAN = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [SW-1:0] r_ptr;
    logic [DW-1:0] r_dwell;

    logic [SW-1:0] w_ptr_nxt;
    logic [DW-1:0] w_dwell_nxt;
    logic          w_free;
    logic          w_load;
    logic          w_clear;
    logic [W-1:0]  w_load_y;
    logic [SW-1:0] w_load_ch;
    logic [W-1:0]  w_sel_data;
    logic [W-1:0]  w_ptr_data;
    logic [SW-1:0] w_first_ch;   // channel a fresh scan starts on
    logic [SW-1:0] w_adv_ch;     // channel after r_ptr in scan order
    logic          w_any_ch;     // at least one channel is scannable

    // ------------------------------------------------------------------
    // Channel data muxes; loops keep every select in range, so an
    // out-of-range sel naturally reads as zero.
    // ------------------------------------------------------------------
    always_comb begin
        w_sel_data = '0;
        w_ptr_data = '0;
        for (int k = 0; k < NCH; k++) begin
            if (SW'(k) == sel)   w_sel_data = d[k*W +: W];
            if (SW'(k) == r_ptr) w_ptr_data = d[k*W +: W];
        end
    end

    // ------------------------------------------------------------------
    // Scan order
    // ------------------------------------------------------------------
`ifdef SCAN_MASK_EN
    logic [SW-1:0] w_above_ch;
    logic          w_above_hit;

    // Descending loops leave the lowest matching channel in place: the
    // lowest enabled channel overall, and the lowest enabled one above
    // the pointer. With nothing above, the search wraps to the lowest.
    always_comb begin
        w_first_ch  = '0;
        w_above_ch  = '0;
        w_above_hit = 1'b0;
        for (int k = NCH - 1; k >= 0; k--) begin
            if (ch_mask[k]) begin
                w_first_ch = SW'(k);
                if (SW'(k) > r_ptr) begin
                    w_above_ch  = SW'(k);
                    w_above_hit = 1'b1;
                end
            end
        end
        w_adv_ch = w_above_hit ? w_above_ch : w_first_ch;
        w_any_ch = |ch_mask;
    end
`else
    always_comb begin
        w_first_ch = '0;
        w_adv_ch   = (r_ptr == c_last_ch) ? '0 : r_ptr + SW'(1);
        w_any_ch   = 1'b1;
    end
`endif

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_DIS;
        else        r_state <= w_state_nxt;
    end

    // ------------------------------------------------------------------
    // Next state and sample decision. The action on each edge follows
    // the state being entered, so a mode change takes effect on the very
    // edge that sees it.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = g_n ? ST_DIS : (mode ? ST_SCAN : ST_MAN);
        w_free      = ~y_valid | y_ready;
        w_load      = 1'b0;
        w_clear     = 1'b0;
        w_load_y    = w_ptr_data;
        w_load_ch   = r_ptr;
        w_ptr_nxt   = r_ptr;
        w_dwell_nxt = r_dwell;

        case (w_state_nxt)
            ST_MAN: begin
                w_ptr_nxt   = '0;
                w_dwell_nxt = '0;
                w_load      = w_free;
                w_load_y    = w_sel_data;
                w_load_ch   = sel;
            end
            ST_SCAN: begin
                if (r_state != ST_SCAN) begin
                    // Fresh entry: restart the walk, first sample DWELL later
                    w_ptr_nxt   = w_first_ch;
                    w_dwell_nxt = '0;
                end else if (r_dwell != c_dwell_max) begin
                    w_dwell_nxt = r_dwell + DW'(1);
                end else if (w_free && w_any_ch) begin
                    w_load      = 1'b1;
                    w_ptr_nxt   = w_adv_ch;
                    w_dwell_nxt = '0;
                end
                // else: dwell expired but slot busy, hold pointer and dwell
            end
            default: begin
                w_clear     = 1'b1;
                w_ptr_nxt   = '0;
                w_dwell_nxt = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Pointer, dwell counter and output stage
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr   <= '0;
            r_dwell <= '0;
            y       <= '0;
            y_ch    <= '0;
            y_valid <= 1'b0;
        end else begin
            r_ptr   <= w_ptr_nxt;
            r_dwell <= w_dwell_nxt;
            if (w_clear) begin
                // Disable drops any pending sample regardless of y_ready
                y       <= '0;
                y_ch    <= '0;
                y_valid <= 1'b0;
            end else if (w_load) begin
                y       <= w_load_y;
                y_ch    <= w_load_ch;
                y_valid <= 1'b1;
            end else if (y_ready) begin
                y_valid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mux_scan_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux_scan_seq
// Purpose  : Directed self-checking bench for mux_scan_seq (NCH=4, W=8,
//            DWELL=4). Define SCAN_MASK_EN to include the mask scenario.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mux_scan_seq;

    localparam int NCH   = 4;
    localparam int W     = 8;
    localparam int DWELL = 4;
    localparam int SW    = 2;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           g_n;
    logic           mode;
    logic [SW-1:0]  sel;
    logic [NCH*W-1:0] d;
    logic [NCH-1:0] ch_mask;
    logic [W-1:0]   y;
    logic [SW-1:0]  y_ch;
    logic           y_valid;
    logic           y_ready;

    int n_checks = 0;
    int n_fail   = 0;

    mux_scan_seq #(.NCH(NCH), .W(W), .DWELL(DWELL)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .g_n     (g_n),
        .mode    (mode),
        .sel     (sel),
        .d       (d),
`ifdef SCAN_MASK_EN
        .ch_mask (ch_mask),
`endif
        .y       (y),
        .y_ch    (y_ch),
        .y_valid (y_valid),
        .y_ready (y_ready)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 ns after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Channel k carries 8'h11*(k+1) in the default data pattern
    function automatic logic [W-1:0] chdat(input int k);
        return 8'h11 * (k + 1);
    endfunction

    task automatic test_reset();
        rst_n = 1'b1; g_n = 1'b1; mode = 1'b0; sel = '0; y_ready = 1'b1;
        ch_mask = '0;
        d = {8'h44, 8'h33, 8'h22, 8'h11};
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (y !== 8'h00) begin n_fail++; $display("FAIL reset_y got=%h exp=00", y); end
        n_checks++; if (y_ch !== 2'd0) begin n_fail++; $display("FAIL reset_ych got=%0d exp=0", y_ch); end
        n_checks++; if (y_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", y_valid); end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_manual();
        g_n = 1'b0; mode = 1'b0; y_ready = 1'b1; sel = 2'd2;
        tick();
        n_checks++; if (y !== 8'h33) begin n_fail++; $display("FAIL man_sel2_y got=%h exp=33", y); end
        n_checks++; if (y_ch !== 2'd2) begin n_fail++; $display("FAIL man_sel2_ych got=%0d exp=2", y_ch); end
        n_checks++; if (y_valid !== 1'b1) begin n_fail++; $display("FAIL man_sel2_valid got=%b exp=1", y_valid); end
        // Back-pressure: held sample survives a select change
        y_ready = 1'b0; sel = 2'd1;
        tick();
        n_checks++; if (y !== 8'h33) begin n_fail++; $display("FAIL man_hold_y got=%h exp=33", y); end
        n_checks++; if (y_ch !== 2'd2) begin n_fail++; $display("FAIL man_hold_ych got=%0d exp=2", y_ch); end
        y_ready = 1'b1;
        tick();
        n_checks++; if (y !== 8'h22) begin n_fail++; $display("FAIL man_sel1_y got=%h exp=22", y); end
        n_checks++; if (y_ch !== 2'd1) begin n_fail++; $display("FAIL man_sel1_ych got=%0d exp=1", y_ch); end
        sel = 2'd3;
        tick();
        n_checks++; if (y !== 8'h44) begin n_fail++; $display("FAIL man_sel3_y got=%h exp=44", y); end
        // Disable drops the pending sample even without y_ready
        y_ready = 1'b0; g_n = 1'b1;
        tick();
        n_checks++; if (y !== 8'h00) begin n_fail++; $display("FAIL dis_y got=%h exp=00", y); end
        n_checks++; if (y_valid !== 1'b0) begin n_fail++; $display("FAIL dis_valid got=%b exp=0", y_valid); end
        y_ready = 1'b1;
        tick();
    endtask

    task automatic test_scan_wrap();
        int ch;
        g_n = 1'b1; tick();
        g_n = 1'b0; mode = 1'b1; y_ready = 1'b1;
        tick();  // entry edge
        n_checks++; if (y_valid !== 1'b0) begin n_fail++; $display("FAIL scan_entry_valid got=%b exp=0", y_valid); end
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (c % 4 == 0) begin
                ch = (c / 4 - 1) % 4;
                n_checks++; if (y_valid !== 1'b1) begin n_fail++; $display("FAIL scan_valid c=%0d got=%b exp=1", c, y_valid); end
                n_checks++; if (y_ch !== SW'(ch)) begin n_fail++; $display("FAIL scan_ych c=%0d got=%0d exp=%0d", c, y_ch, ch); end
                n_checks++; if (y !== chdat(ch)) begin n_fail++; $display("FAIL scan_y c=%0d got=%h exp=%h", c, y, chdat(ch)); end
            end else begin
                n_checks++; if (y_valid !== 1'b0) begin n_fail++; $display("FAIL scan_idle c=%0d got=%b exp=0", c, y_valid); end
            end
        end
    endtask

    task automatic test_back_pressure();
        g_n = 1'b1; tick();
        g_n = 1'b0; mode = 1'b1; y_ready = 1'b1;
        tick();
        repeat (3) tick();
        tick();
        n_checks++; if (y_ch !== 2'd0 || y_valid !== 1'b1) begin n_fail++; $display("FAIL bp_first got ch=%0d v=%b exp ch=0 v=1", y_ch, y_valid); end
        y_ready = 1'b0;
        d[7:0] = 8'hAA;  // source change must not disturb the held sample
        for (int i = 1; i <= 10; i++) begin
            tick();
            n_checks++; if (y !== 8'h11 || y_ch !== 2'd0 || y_valid !== 1'b1) begin
                n_fail++; $display("FAIL bp_hold i=%0d got y=%h ch=%0d v=%b exp y=11 ch=0 v=1", i, y, y_ch, y_valid);
            end
        end
        y_ready = 1'b1;
        d[7:0] = 8'h11;
        tick();
        n_checks++; if (y !== 8'h22 || y_ch !== 2'd1 || y_valid !== 1'b1) begin
            n_fail++; $display("FAIL bp_release got y=%h ch=%0d v=%b exp y=22 ch=1 v=1", y, y_ch, y_valid);
        end
        tick();
        n_checks++; if (y_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drain got=%b exp=0", y_valid); end
        repeat (2) tick();
        tick();
        n_checks++; if (y !== 8'h33 || y_ch !== 2'd2) begin n_fail++; $display("FAIL bp_next got y=%h ch=%0d exp y=33 ch=2", y, y_ch); end
    endtask

    task automatic test_mode_switch();
        g_n = 1'b0; mode = 1'b0; sel = 2'd3; y_ready = 1'b1;
        tick();
        tick();
        n_checks++; if (y !== 8'h44 || y_ch !== 2'd3) begin n_fail++; $display("FAIL ms_man got y=%h ch=%0d exp y=44 ch=3", y, y_ch); end
        mode = 1'b1;
        tick();  // entry edge
        for (int c = 1; c <= 3; c++) begin
            tick();
            n_checks++; if (y_valid !== 1'b0) begin n_fail++; $display("FAIL ms_wait c=%0d got=%b exp=0", c, y_valid); end
        end
        tick();
        n_checks++; if (y !== 8'h11 || y_ch !== 2'd0 || y_valid !== 1'b1) begin
            n_fail++; $display("FAIL ms_first got y=%h ch=%0d v=%b exp y=11 ch=0 v=1", y, y_ch, y_valid);
        end
    endtask

    task automatic test_reset_midop();
        // Previous scenario leaves a valid scan sample on the output
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (y !== 8'h00 || y_ch !== 2'd0 || y_valid !== 1'b0) begin
            n_fail++; $display("FAIL mid_reset got y=%h ch=%0d v=%b exp all 0", y, y_ch, y_valid);
        end
        #1 rst_n = 1'b1;
        tick();  // entry edge after release
        for (int c = 1; c <= 3; c++) begin
            tick();
            n_checks++; if (y_valid !== 1'b0) begin n_fail++; $display("FAIL rel_wait c=%0d got=%b exp=0", c, y_valid); end
        end
        tick();
        n_checks++; if (y !== 8'h11 || y_ch !== 2'd0 || y_valid !== 1'b1) begin
            n_fail++; $display("FAIL rel_first got y=%h ch=%0d v=%b exp y=11 ch=0 v=1", y, y_ch, y_valid);
        end
    endtask

`ifdef SCAN_MASK_EN
    task automatic test_scan_mask();
        int ch;
        g_n = 1'b1; tick();
        ch_mask = 4'b1010;
        g_n = 1'b0; mode = 1'b1; y_ready = 1'b1;
        tick();
        for (int s = 0; s < 4; s++) begin
            repeat (3) tick();
            tick();
            ch = (s % 2 == 0) ? 1 : 3;
            n_checks++; if (y_ch !== SW'(ch) || y !== chdat(ch) || y_valid !== 1'b1) begin
                n_fail++; $display("FAIL mask_seq s=%0d got ch=%0d y=%h v=%b exp ch=%0d", s, y_ch, y, y_valid, ch);
            end
        end
        ch_mask = 4'b0000;
        for (int i = 1; i <= 12; i++) begin
            tick();
            n_checks++; if (y_valid !== 1'b0) begin n_fail++; $display("FAIL mask_zero i=%0d got=%b exp=0", i, y_valid); end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_manual();
        test_scan_wrap();
        test_back_pressure();
        test_mode_switch();
        test_reset_midop();
`ifdef SCAN_MASK_EN
        test_scan_mask();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
